// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default latencies and the long-op decode. Optional divider: MDU_DIV_EN.
package mdu_pkg;

    // md_op_E encodings (6 and 7 are reserved)
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Sequencer states
    localparam logic [0:0] MDU_IDLE = 1'b0;
    localparam logic [0:0] MDU_RUN  = 1'b1;

    // Default busy latencies
    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    // Ops that occupy the unit for several cycles. Without the divider,
    // div/divu decode as reserved and never start a run.
    function automatic logic is_long_op(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return (op <= MD_DIVU);
`else
        return (op <= MD_MULTU);
`endif
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit datapath of the MDU: product for mult/multu and,
// when MDU_DIV_EN is defined, quotient/remainder for div/divu. Any op that
// produces no result (including divide by zero) passes the current HI/LO.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

`ifdef MDU_DIV_EN
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Sign-magnitude divide: truncates toward zero, remainder takes the
    // dividend's sign; 0x80000000 / -1 wraps back to 0x80000000.
    always_comb begin
        a_neg = (op == MD_DIV) & a[31];
        b_neg = (op == MD_DIV) & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        if (b_mag == 32'd0) begin
            b_mag = 32'd1;  // result is discarded on divide by zero
        end
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem   = a_neg ? (32'd0 - r_mag) : r_mag;
    end
`endif

    // Result select: product, quotient/remainder or HI/LO pass-through
    always_comb begin
        a_ext  = (op == MD_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext  = (op == MD_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
        prod   = a_ext * b_ext;
        res_hi = cur_hi;
        res_lo = cur_lo;
        if (op == MD_MULT || op == MD_MULTU) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
`ifdef MDU_DIV_EN
        if ((op == MD_DIV || op == MD_DIVU) && b != 32'd0) begin
            res_hi = rem;
            res_lo = quot;
        end
`endif
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit for pipeline stage E: HI/LO registers, a countdown
// sequencer that models multi-cycle latency, and the D/E stall request.
// Divider is compiled only when MDU_DIV_EN is defined.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic [2:0]  md_op_E,
    input  logic [31:0] a_E,
    input  logic [31:0] b_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MDU_DIV_EN
    localparam int unsigned CNT_MAX = DIV_CYCLES;
`else
    localparam int unsigned CNT_MAX = MULT_CYCLES;
`endif
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
`ifdef MDU_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
`endif
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (MULT_CYCLES < 1 || DIV_CYCLES < MULT_CYCLES) begin : g_bad_cfg
        $error("mdu_ctrl: need MULT_CYCLES >= 1 and DIV_CYCLES >= MULT_CYCLES");
    end

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             start_long;

    mdu_arith u_arith (
        .op     (md_op_E),
        .a      (a_E),
        .b      (b_E),
        .cur_hi (hi),
        .cur_lo (lo),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Busy flag and stall: a D-stage MDU op must wait while a run is in
    // flight or about to start from stage E.
    always_comb begin
        start_long = start_E & is_long_op(md_op_E);
        busy       = (state == MDU_RUN);
        stall_req  = md_use_D & (busy | start_long);
    end

    // Sequencer, countdown, pending result and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MDU_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (state == MDU_RUN) begin
            // New starts are ignored here; the stall keeps them away.
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                hi    <= pend_hi;
                lo    <= pend_lo;
                state <= MDU_IDLE;
            end
        end else if (start_E) begin
            if (start_long) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                state   <= MDU_RUN;
`ifdef MDU_DIV_EN
                cnt     <= (md_op_E <= MD_MULTU) ? MULT_LOAD : DIV_LOAD;
`else
                cnt     <= MULT_LOAD;
`endif
            end else if (md_op_E == MD_MTHI) begin
                hi <= a_E;
            end else if (md_op_E == MD_MTLO) begin
                lo <= a_E;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a cycle-level reference model pushes the
// expected HI/LO and busy length of each accepted write op; a monitor pops
// and compares when the DUT commits. Honours MDU_DIV_EN like the design.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_E = 1'b0;
    logic [2:0]  md_op_E = 3'd0;
    logic [31:0] a_E = '0;
    logic [31:0] b_E = '0;
    logic        md_use_D = 1'b0;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_E   (start_E),
        .md_op_E   (md_op_E),
        .a_E       (a_E),
        .b_E       (b_E),
        .md_use_D  (md_use_D),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    bit          started = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_pend_hi = '0;
    logic [31:0] m_pend_lo = '0;
    int          m_busy_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit long_op(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return op <= 3'd3;
`else
        return op <= 3'd1;
`endif
    endfunction

    // {hi, lo} an op should leave behind, by plain 64-bit arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint          sa, sb_;
        longint unsigned ua, ub;
        longint          q, r;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = {h, l};
        case (op)
            3'd0: res = sa * sb_;
            3'd1: res = ua * ub;
            3'd2: if (b != 0) begin
                q = sa / sb_;
                r = sa % sb_;
                res = {r[31:0], q[31:0]};
            end
            3'd3: if (b != 0) begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
                res = {r[31:0], q[31:0]};
            end
            default: res = {h, l};
        endcase
        return res;
    endfunction

    // Reference model: advances one clock edge at a time
    always @(posedge clk) begin
        logic [63:0] r;
        if (reset) begin
            started     = 1'b1;
            m_hi        = '0;
            m_lo        = '0;
            m_pend_hi   = '0;
            m_pend_lo   = '0;
            m_busy_left = 0;
            sb.delete();
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_hi = m_pend_hi;
                m_lo = m_pend_lo;
            end
        end else if (start_E) begin
            if (long_op(md_op_E)) begin
                r           = ref_result(md_op_E, a_E, b_E, m_hi, m_lo);
                m_pend_hi   = r[63:32];
                m_pend_lo   = r[31:0];
                m_busy_left = (md_op_E <= 3'd1) ? MULT_N : DIV_N;
                sb.push_back('{r[63:32], r[31:0], m_busy_left});
            end else if (md_op_E == 3'd4) begin
                m_hi = a_E;
                sb.push_back('{m_hi, m_lo, 0});
            end else if (md_op_E == 3'd5) begin
                m_lo = a_E;
                sb.push_back('{m_hi, m_lo, 0});
            end
        end
    end

    // Monitor: per-cycle output checks plus scoreboard pops on each commit
    bit prev_busy = 1'b0;
    bit rst_prev  = 1'b0;
    bit mt_flag   = 1'b0;
    int busy_run  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            check("busy", busy, 64'(m_busy_left > 0));
            check("stall_req", stall_req,
                  64'(md_use_D && (m_busy_left > 0 || (start_E && long_op(md_op_E)))));
            check("hi_cycle", hi, m_hi);
            check("lo_cycle", lo, m_lo);
            if (mt_flag) begin
                if (sb.size() == 0) begin
                    check("sb_mt_entry", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("sb_mt_hi", hi, e.hi);
                    check("sb_mt_lo", lo, e.lo);
                end
            end
            mt_flag = start_E && !reset && m_busy_left == 0 &&
                      (md_op_E == 3'd4 || md_op_E == 3'd5);
            if (busy) begin
                busy_run++;
            end else begin
                if (prev_busy && !rst_prev) begin
                    if (sb.size() == 0) begin
                        check("sb_commit_entry", 64'(sb.size()), 64'd1);
                    end else begin
                        e = sb.pop_front();
                        check("sb_hi", hi, e.hi);
                        check("sb_lo", lo, e.lo);
                        check("sb_busy_len", 64'(busy_run), 64'(e.n));
                    end
                end
                busy_run = 0;
            end
            if (reset) busy_run = 0;
            prev_busy = busy;
            rst_prev  = reset;
        end
    end

    task automatic drive(input logic rst, input logic s, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic use_d);
        @(posedge clk);
        #2;
        reset    = rst;
        start_E  = s;
        md_op_E  = op;
        a_E      = a;
        b_E      = b;
        md_use_D = use_d;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(1'b0, 1'b1, op, a, b, 1'b0);
    endtask

    task automatic idle(input int n, input logic use_d);
        repeat (n) drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, use_d);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 64 && (busy || m_busy_left != 0); i++) @(negedge clk);
        if (i == 64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: busy=%0b after 64 cycles, expected 0", busy);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", busy, 1'b0);

        // mult -2 * 3 with a D-stage MDU op waiting throughout
        drive(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        idle(MULT_N + 2, 1'b1);
        idle(1, 1'b0);
        wait_idle();
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        idle(1, 1'b0);
        wait_idle();
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        // mtlo while idle: visible next cycle, never busy
        issue(3'd5, 32'h1234, 32'd0);
        idle(1, 1'b0);
        @(negedge clk);
        check("mtlo_lo", lo, 32'h1234);
        check("mtlo_busy", busy, 1'b0);

        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        issue(3'd2, 32'h55, 32'd0);
        idle(1, 1'b0);
        wait_idle();
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        idle(1, 1'b0);
        wait_idle();
`ifdef MDU_DIV_EN
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);
`else
        check("div_off_hi", hi, 32'h11);
        check("div_off_lo", lo, 32'h22);
`endif

        issue(3'd3, 32'd7, 32'd2);
        idle(1, 1'b0);
        wait_idle();
`ifdef MDU_DIV_EN
        check("divu_hi", hi, 32'd1);
        check("divu_lo", lo, 32'd3);
`else
        check("divu_off_hi", hi, 32'h11);
        check("divu_off_lo", lo, 32'h22);
`endif

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(1, 1'b0);
        wait_idle();
`ifdef MDU_DIV_EN
        check("div_ovf_hi", hi, 32'd0);
        check("div_ovf_lo", lo, 32'h8000_0000);
`else
        check("div_ovf_off_lo", lo, 32'h22);
`endif

        // mthi while running is ignored
        issue(3'd0, 32'd5, 32'd6);
        issue(3'd4, 32'hDEAD, 32'd0);
        idle(1, 1'b0);
        wait_idle();
        check("mthi_run_hi", hi, 32'd0);
        check("mthi_run_lo", lo, 32'd30);

        // Back-to-back: start in the last busy cycle ignored, next cycle taken
        issue(3'd0, 32'd9, 32'd9);
        idle(MULT_N - 1, 1'b0);
        issue(3'd5, 32'hBAD, 32'd0);
        issue(3'd1, 32'h10000, 32'h10000);
        idle(1, 1'b0);
        wait_idle();
        check("b2b_hi", hi, 32'd1);
        check("b2b_lo", lo, 32'd0);

        // Reset in the third busy cycle aborts the run
        issue(3'd1, 32'd3, 32'd4);
        idle(2, 1'b0);
        drive(1'b1, 1'b1, 3'd4, 32'h77, 32'd0, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", busy, 1'b0);
        idle(MULT_N + 2, 1'b0);
        @(negedge clk);
        check("abort_nocommit_lo", lo, 32'd0);

        // Randomized traffic, including starts during a run and stray resets
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(63) == 0), 1'($urandom_range(1)),
                  3'($urandom_range(7)), rnd_val(),
                  ($urandom_range(7) == 0) ? 32'd0 : rnd_val(), 1'($urandom_range(1)));
        end
        idle(1, 1'b0);
        wait_idle();
        idle(2, 1'b0);
        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit with its own sequencing controller, sitting beside the ALU in stage E of the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo from stage E and models multi-cycle latency with a countdown FSM. It owns the HI/LO registers and raises a stall request to the D/E pipeline registers while a D-stage MDU instruction would collide with an operation in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1, ≥ MULT_CYCLES)
- clk  in  1  clock; one clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start_E  in  1  stage-E instruction is an MDU write op (md_op_E valid)
- md_op_E  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 reserved
- a_E  in  32  forwarded rs value
- b_E  in  32  forwarded rt value
- md_use_D  in  1  stage-D instruction is any MDU instruction (incl. mfhi/mflo)
- busy  out  1  operation in flight
- stall_req  out  1  freeze PC/D, bubble E
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, RUN. Down-counter cnt, width $clog2(DIV_CYCLES+1).
- IDLE, start_E, op 0–3: compute 64-bit result from a_E/b_E, latch into pend_hi/pend_lo; cnt ← MULT_CYCLES or DIV_CYCLES; → RUN.
- mult: signed 32×32 → {hi,lo}; multu unsigned. div: lo = quotient, hi = remainder, truncation toward zero, remainder sign follows dividend; divu unsigned.
- Divide by zero: pend_hi/pend_lo ← current hi/lo (registers unchanged); full DIV_CYCLES busy still taken.
- IDLE, start_E, op 4/5: hi (mthi) or lo (mtlo) ← a_E at that edge; no busy, stay IDLE.
- Reserved op with start_E: no effect.
- RUN: cnt decrements each cycle; at the edge where cnt==1, hi/lo ← pend_hi/pend_lo, → IDLE.
- start_E while RUN: ignored entirely (stall logic guarantees it does not occur; bench checks no corruption).
- busy = (state==RUN).
- stall_req = md_use_D & (busy | (start_E & md_op_E≤3)); combinational.
- -32768-style edge: div 0x80000000 / 0xFFFFFFFF → lo 0x80000000, hi 0 (wraps, no trap).

## Timing
- Reset values: hi 0, lo 0, busy 0, stall_req 0 (given md_use_D=0), state IDLE, cnt 0, pend regs 0.
- start_E sampled at edge t → busy high in cycles t+1 … t+N (N = MULT/DIV_CYCLES); hi/lo new value visible from t+N+1, same cycle busy falls.
- mthi/mtlo: new value visible cycle after the edge; zero stall.
- Back-to-back: new start accepted in the first cycle busy is low.
- Reset in RUN: abort, pending result discarded, all outputs to reset values next cycle.
- Reset and start_E same cycle: reset wins.

## Configuration
- MDU_DIV_EN defined: div/divu as above.
- Undefined: divider logic not compiled; op 2/3 treated as reserved (no busy, hi/lo unchanged); DIV_CYCLES unused, cnt width from MULT_CYCLES.

## Structure
- Package mdu_pkg: op encodings (MD_MULT … MD_MTLO), state enum (MDU_IDLE, MDU_RUN), default cycle constants.
- One sub-module: mdu_arith — combinational 64-bit product/quotient/remainder from op, a, b, with div-by-zero pass-through of current hi/lo; divide path under MDU_DIV_EN.
- mdu_ctrl keeps FSM, counter, pending and HI/LO registers, stall logic.

## Test plan
- mult a=0xFFFFFFFE (-2), b=3 → busy for 5 cycles; hi 0xFFFFFFFF, lo 0xFFFFFFFA at cycle t+6; multu same operands → hi 0x00000002, lo 0xFFFFFFFA.
- div a=-7, b=2 → after 10 busy cycles lo 0xFFFFFFFD, hi 0xFFFFFFFF; divu 7/2 → lo 3, hi 1.
- div by zero with hi=0x11, lo=0x22 → busy 10 cycles, hi/lo stay 0x11/0x22.
- md_use_D=1 during busy and on start_E cycle → stall_req=1 each such cycle; drops in cycle busy falls; md_use_D=0 → stall_req=0.
- mtlo a=0x1234 while IDLE → lo 0x1234 next cycle, busy never rises; mthi during RUN ignored.
- reset asserted at cycle 3 of a mult → next cycle hi=lo=0, busy 0; no later commit.
